// File: rtl/int_regfile_mp.sv
// Multi-read-port integer register file: NRD registered read ports, one write port,
// x0 reads zero, sequential clear engine. Define INT_RF_BYPASS_EN for write-first same-edge reads.
`timescale 1ns/1ps

module int_regfile_mp_rd #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clr_act,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              wr_vld,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  output logic [XLEN-1:0]   data
);
  logic            addr_ok;
  logic [XLEN-1:0] data_nxt;

  // Power-of-two NREG has no out-of-range addresses, so only x0 needs masking.
  if (NREG == (1 << ADDR_W)) begin : g_full
    assign addr_ok = (addr != '0);
  end else begin : g_part
    localparam logic [ADDR_W-1:0] NREG_A = ADDR_W'(NREG);
    assign addr_ok = (addr != '0) && (addr < NREG_A);
  end

  always_comb begin
    data_nxt = '0;
    if (!clr_act && addr_ok) begin
`ifdef INT_RF_BYPASS_EN
      data_nxt = (wr_vld && (wr_addr == addr)) ? wr_data : mem_rdata;
`else
      data_nxt = mem_rdata;
`endif
    end
  end

`ifndef INT_RF_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_vld, wr_addr, wr_data};
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)     data <= '0;
    else if (rd_en) data <= data_nxt;
  end
endmodule

module int_regfile_mp #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [NRD-1:0]         rd_en_in,
  input  logic [NRD*ADDR_W-1:0]  rs_addr_in,
  output logic [NRD*XLEN-1:0]    rs_data_out,
  input  logic                   wr_en_in,
  input  logic [ADDR_W-1:0]      wr_addr_in,
  input  logic [XLEN-1:0]        wr_data_in,
  input  logic                   clr_in,
  output logic                   clr_busy_out
);
  typedef enum logic {CLEAR, IDLE} state_t;
  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
  } wr_req_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);

  state_t                       state, state_nxt;
  logic [ADDR_W-1:0]            cnt, cnt_nxt;
  logic                         clr_act;
  logic                         wr_addr_ok;
  wr_req_t                      wr;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_waddr;
  logic [XLEN-1:0]              mem_wdata;
  logic [XLEN-1:0]              mem [NREG];
  logic [NRD-1:0][ADDR_W-1:0]   rs_addr;
  logic [NRD-1:0][XLEN-1:0]     mem_rdata;
  logic [NRD-1:0][XLEN-1:0]     rd_data;

  assign clr_act      = (state == CLEAR);
  assign clr_busy_out = clr_act;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      IDLE: if (clr_in) begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  if (NREG == (1 << ADDR_W)) begin : g_wfull
    assign wr_addr_ok = (wr_addr_in != '0);
  end else begin : g_wpart
    localparam logic [ADDR_W-1:0] NREG_A = ADDR_W'(NREG);
    assign wr_addr_ok = (wr_addr_in != '0) && (wr_addr_in < NREG_A);
  end

  assign wr.vld  = !clr_act && wr_en_in && wr_addr_ok;
  assign wr.addr = wr_addr_in;
  assign wr.data = wr_data_in;

  // Single write port shared by the clear engine and external writes keeps the array RAM-mappable.
  always_comb begin
    mem_we    = wr.vld;
    mem_waddr = wr.addr;
    mem_wdata = wr.data;
    if (clr_act) begin
      mem_we    = 1'b1;
      mem_waddr = cnt;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rs_addr     = rs_addr_in;
  assign rs_data_out = rd_data;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    assign mem_rdata[k] = mem[rs_addr[k]];
    int_regfile_mp_rd #(.XLEN(XLEN), .NREG(NREG), .ADDR_W(ADDR_W)) u_rd (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .clr_act   (clr_act),
      .rd_en     (rd_en_in[k]),
      .addr      (rs_addr[k]),
      .mem_rdata (mem_rdata[k]),
      .wr_vld    (wr.vld),
      .wr_addr   (wr.addr),
      .wr_data   (wr.data),
      .data      (rd_data[k])
    );
  end
endmodule

// File: tb/tb_int_regfile_mp.sv
// Bench for int_regfile_mp: directed steps plus random traffic against an array model,
// with a second NREG=24/NRD=3 instance for the non-power-of-two boundary.
`timescale 1ns/1ps

module tb_int_regfile_mp;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int NRD    = 2;
  localparam int AW     = 5;
  localparam int NREG_B = 24;
  localparam int NRD_B  = 3;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                 rst_in;
  logic [NRD-1:0]       rd_en_in;
  logic [NRD*AW-1:0]    rs_addr_in;
  logic [NRD*XLEN-1:0]  rs_data_out;
  logic                 wr_en_in;
  logic [AW-1:0]        wr_addr_in;
  logic [XLEN-1:0]      wr_data_in;
  logic                 clr_in, clr_busy_out;

  logic [NRD_B-1:0]      rd_en_b;
  logic [NRD_B*AW-1:0]   rs_addr_b;
  logic [NRD_B*XLEN-1:0] rs_data_b;
  logic                  wr_en_b;
  logic [AW-1:0]         wr_addr_b;
  logic [XLEN-1:0]       wr_data_b;
  logic                  clr_b, clr_busy_b;

  int_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rd_en_in(rd_en_in), .rs_addr_in(rs_addr_in),
    .rs_data_out(rs_data_out), .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
    .wr_data_in(wr_data_in), .clr_in(clr_in), .clr_busy_out(clr_busy_out));

  int_regfile_mp #(.XLEN(XLEN), .NREG(NREG_B), .NRD(NRD_B)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .rd_en_in(rd_en_b), .rs_addr_in(rs_addr_b),
    .rs_data_out(rs_data_b), .wr_en_in(wr_en_b), .wr_addr_in(wr_addr_b),
    .wr_data_in(wr_data_b), .clr_in(clr_b), .clr_busy_out(clr_busy_b));

  int total = 0;
  int bad   = 0;

  // Reference: architectural register contents, last loaded value per port, clear edges left.
  logic [XLEN-1:0] m_mem [NREG];
  logic [XLEN-1:0] m_out [NRD];
  int              m_clr_left;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit wv;
    if (rst_in) begin
      foreach (m_out[k]) m_out[k] = '0;
      foreach (m_mem[i]) m_mem[i] = '0;
      m_clr_left = NREG;
      return;
    end
    wv = (m_clr_left == 0) && wr_en_in && (wr_addr_in != 0);
    for (int k = 0; k < NRD; k++) begin
      if (rd_en_in[k]) begin
        int a;
        a = int'(rs_addr_in[k*AW +: AW]);
        if (m_clr_left > 0 || a == 0) m_out[k] = '0;
`ifdef INT_RF_BYPASS_EN
        else if (wv && a == int'(wr_addr_in)) m_out[k] = wr_data_in;
`endif
        else m_out[k] = m_mem[a];
      end
    end
    if (m_clr_left > 0) m_clr_left--;
    else begin
      if (wv) m_mem[wr_addr_in] = wr_data_in;
      // Everything is unobservable during a clear and ends as zero.
      if (clr_in) begin
        m_clr_left = NREG;
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk_in);
    #1;
    for (int k = 0; k < NRD; k++)
      chk($sformatf("%s.p%0d", tag, k), rs_data_out[k*XLEN +: XLEN], m_out[k]);
    chk({tag, ".busy"}, {31'b0, clr_busy_out}, (m_clr_left > 0) ? 32'd1 : 32'd0);
  endtask

  task automatic set_rd(input int k, input bit en, input int a);
    rd_en_in[k] = en;
    rs_addr_in[k*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input bit en, input int a, input logic [XLEN-1:0] d);
    wr_en_in = en; wr_addr_in = AW'(a); wr_data_in = d;
  endtask

  task automatic set_rd_b(input int k, input int a);
    rd_en_b[k] = 1'b1;
    rs_addr_b[k*AW +: AW] = AW'(a);
  endtask

  initial begin
    int n, nb;
    rst_in = 1'b1; clr_in = 1'b0; rd_en_in = '0; rs_addr_in = '0;
    set_wr(0, 0, '0);
    rd_en_b = '0; rs_addr_b = '0; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; clr_b = 1'b0;

    step("rst0");
    step("rst1");
    chk("b_rst_busy", {31'b0, clr_busy_b}, 32'd1);
    chk("b_rst_data", rs_data_b[XLEN-1:0], '0);
    rst_in = 1'b0;

    // Clear length after reset release, both instances.
    n = 0; nb = 0;
    do begin
      step("init_clr");
      n++;
      if (!clr_busy_b && nb == 0) nb = n;
    end while (clr_busy_out && n < 100);
    chk("init_clr_len", n, NREG);
    chk("b_init_clr_len", nb, NREG_B);

    for (int a = 0; a < NREG; a++) begin
      set_rd(0, 1, a); set_rd(1, 1, NREG - 1 - a);
      step("zero_scan");
    end

    set_wr(1, 5, 32'hDEADBEEF); set_rd(0, 0, 0); set_rd(1, 0, 0);
    step("wr_x5");
    set_wr(0, 0, '0); set_rd(0, 1, 5); set_rd(1, 1, 5);
    step("rd_x5");
    chk("x5_p0", rs_data_out[XLEN-1:0], 32'hDEADBEEF);
    chk("x5_p1", rs_data_out[2*XLEN-1:XLEN], 32'hDEADBEEF);
    set_wr(1, 0, 32'h1234); set_rd(0, 0, 0); set_rd(1, 0, 0);
    step("wr_x0");
    set_wr(0, 0, '0); set_rd(0, 1, 0);
    step("rd_x0");
    chk("x0_zero", rs_data_out[XLEN-1:0], '0);

    set_wr(1, 7, 32'h11); set_rd(0, 0, 0);
    step("wr_x7");
    set_wr(1, 7, 32'hA5A5A5A5); set_rd(0, 1, 7);
    step("same_edge");
`ifdef INT_RF_BYPASS_EN
    chk("same_edge_x7", rs_data_out[XLEN-1:0], 32'hA5A5A5A5);
`else
    chk("same_edge_x7", rs_data_out[XLEN-1:0], 32'h11);
`endif
    set_wr(0, 0, '0);
    step("after_edge");
    chk("after_edge_x7", rs_data_out[XLEN-1:0], 32'hA5A5A5A5);

    set_wr(1, 3, 32'h33); set_rd(0, 0, 0); set_rd(1, 0, 0);
    step("wr_x3");
    set_wr(0, 0, '0); set_rd(1, 1, 3);
    step("rd_x3");
    set_wr(1, 3, 32'h33330000); set_rd(1, 0, 9); set_rd(0, 1, 3);
    step("hold1");
    chk("hold_p1_a", rs_data_out[2*XLEN-1:XLEN], 32'h33);
    set_wr(0, 0, '0);
    step("hold2");
    chk("hold_p1_b", rs_data_out[2*XLEN-1:XLEN], 32'h33);
    chk("upd_p0", rs_data_out[XLEN-1:0], 32'h33330000);

    for (int i = 0; i < 300; i++) begin
      rd_en_in = NRD'($urandom);
      rs_addr_in = (NRD*AW)'($urandom);
      set_wr($urandom_range(1), $urandom_range(NREG - 1), $urandom);
      clr_in = ($urandom_range(59) == 0);
      step("rand");
    end
    clr_in = 1'b0; set_wr(0, 0, '0);
    n = 0;
    while (clr_busy_out && n < 100) begin step("rand_drain"); n++; end

    for (int a = 1; a < NREG; a++) begin
      set_wr(1, a, 32'h100 + a);
      step("fill");
    end
    set_wr(1, 4, 32'hCAFE); clr_in = 1'b1;
    step("clr_req");
    clr_in = 1'b0;
    n = 0;
    while (clr_busy_out && n < 100) begin
      set_wr(1, 9, 32'hFFFF); set_rd(0, 1, 9); set_rd(1, 1, 4);
      step("clr_busy");
      n++;
    end
    chk("clr_len", n, NREG);
    set_wr(0, 0, '0);
    for (int a = 0; a < NREG; a += 2) begin
      set_rd(0, 1, a); set_rd(1, 1, a + 1);
      step("post_clr");
      chk("post_clr_p0", rs_data_out[XLEN-1:0], '0);
      chk("post_clr_p1", rs_data_out[2*XLEN-1:XLEN], '0);
    end

    clr_in = 1'b1;
    step("clr_req2");
    clr_in = 1'b0;
    for (int i = 0; i < 10; i++) step("clr_mid");
    rst_in = 1'b1;
    step("mid_rst");
    rst_in = 1'b0;
    n = 0;
    while (clr_busy_out && n < 100) begin step("rst_clr"); n++; end
    chk("rst_restart_len", n, NREG);

    wr_en_b = 1'b1; wr_addr_b = 5'd30; wr_data_b = 32'hBAD0BAD0;
    step("b_wr30");
    wr_addr_b = 5'd23; wr_data_b = 32'h2323;
    step("b_wr23");
    wr_addr_b = 5'd6; wr_data_b = 32'h66;
    step("b_wr6");
    wr_en_b = 1'b0;
    set_rd_b(0, 30); set_rd_b(1, 23); set_rd_b(2, 6);
    step("b_rd");
    chk("b_rd30", rs_data_b[XLEN-1:0], '0);
    chk("b_rd23", rs_data_b[2*XLEN-1:XLEN], 32'h2323);
    chk("b_rd6", rs_data_b[3*XLEN-1:2*XLEN], 32'h66);
    clr_b = 1'b1;
    step("b_clr_req");
    clr_b = 1'b0;
    n = 0;
    while (clr_busy_b && n < 100) begin step("b_clr"); n++; end
    chk("b_clr_len", n, NREG_B);
    step("b_rd_after");
    chk("b_rd23_clr", rs_data_b[2*XLEN-1:XLEN], '0);
    chk("b_rd6_clr", rs_data_b[3*XLEN-1:2*XLEN], '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/int_regfile_mp.md
# int_regfile_mp

Parametrised multi-read-port integer register file for the RISC-V core's decode/execute boundary. Provides NRD registered read ports and one write port, with register 0 hardwired to zero and a sequential clear engine that zeroes the array one entry per cycle after reset or on request. It keeps the array free of any reset fan-out to every entry, so it can map to RAM. It supersedes the fixed two-port, 32×32 register file.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of registers (2..64); ADDR_W = $clog2(NREG) derived locally
- NRD, 2, number of read ports (1..4)

- clk_in  in  1  clock, all state on rising edge
- rst_in  in  1  reset, asynchronous, active-high
- rd_en_in  in  NRD  per-port read enable; bit k controls port k
- rs_addr_in  in  NRD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
- rs_data_out  out  NRD*XLEN  registered read data, port k at [k*XLEN +: XLEN]
- wr_en_in  in  1  write enable
- wr_addr_in  in  ADDR_W  write address
- wr_data_in  in  XLEN  write data
- clr_in  in  1  request a full clear (level-sampled, acted on only in IDLE)
- clr_busy_out  out  1  high while clear engine runs

## Operation
- FSM states: CLEAR, IDLE. rst_in asserted forces CLEAR, clear counter = 0, rs_data_out = 0, clr_busy_out = 1.
- CLEAR: each edge writes 0 to entry[counter], counter++. On the edge clearing entry NREG-1, go IDLE, clr_busy_out = 0. External writes are dropped. Read registers for enabled ports load 0.
- IDLE: clr_in = 1 on an edge sets counter = 0, state = CLEAR and clr_busy_out = 1. Any write on that same edge is still performed, then overwritten by the clear.
- Write (IDLE): wr_en_in & wr_addr_in != 0 & wr_addr_in < NREG writes entry. Writes to address 0 or out-of-range addresses are ignored.
- Read port k (IDLE):
  - rd_en_in[k] = 1: data register loads entry[addr].
  - rd_en_in[k] = 0: data register holds its value.
  - Address 0 or an address >= NREG returns 0.
- Simultaneous read/write of the same valid non-zero address follows the INT_RF_BYPASS_EN rule under Configuration.
- Multiple ports reading the same address each get the same value. Ports are independent.

## Timing
- Read latency 1 cycle: address sampled at edge N, data valid after edge N and stable until the next enabled edge.
- Write visible to a non-bypassed read sampled at edge N+1 or later.
- Clear duration: exactly NREG edges after rst_in deassertion, or after the edge that accepts clr_in.
- rst_in asserted mid-clear or mid-operation restarts the clear from entry 0. Array contents are not reset asynchronously, only by the engine.
- Reset values: rs_data_out = 0, clr_busy_out = 1.

## Configuration
- INT_RF_BYPASS_EN defined: write-first forwarding. A read sampled on the same edge as a valid write to the same address loads wr_data_in.
- INT_RF_BYPASS_EN undefined: read-first. The same-edge read loads the old entry value and needs no forwarding mux. Address-0 and CLEAR behaviour are unchanged.

## Test plan
- Reset release with NREG=32 -> clr_busy_out high for exactly 32 edges. All ports then read 0 from addresses 0..31.
- Write 0xDEADBEEF to x5, then read x5 on port 0 and port 1 the next cycle -> both show 0xDEADBEEF one cycle after the address edge. Write 0x1234 to x0 -> x0 reads 0.
- Same edge: write 0xA5A5A5A5 to x7 while port 0 reads x7, which previously held 0x11 -> 0xA5A5A5A5 with INT_RF_BYPASS_EN defined, 0x11 without. Port 0 reads 0xA5A5A5A5 the following cycle in both builds.
- rd_en_in[1] = 0 while its address changes and x3 is rewritten -> port 1 output holds its previous value. Port 0 with rd_en_in[0] = 1 updates.
- clr_in in IDLE after filling x1..x31 with nonzero values -> 32 busy cycles, writes during busy dropped, all registers read 0 afterwards. rst_in pulsed at busy cycle 10 -> count restarts and busy lasts 32 edges from release.
- NREG=24, NRD=3 build: write to address 30 ignored, read of address 30 returns 0, clear lasts 24 edges.
